// File: rtl/lock_pkg.sv
// lock_pkg: shared state, compare-type and key encodings for the lock datapath
package lock_pkg;
  typedef enum logic [2:0] {
    S_LOCKED     = 3'd0,
    S_LOCKOUT    = 3'd1,
    S_UNLOCKED   = 3'd2,
    S_AUTH_PC    = 3'd3,
    S_NEW_UC     = 3'd4,
    S_CONFIRM_UC = 3'd5,
    S_COMMIT     = 3'd6
  } state_e;
  typedef enum logic [1:0] {
    COMPAREPC = 2'b00,
    COMPAREUC = 2'b01,
    MATCHUC   = 2'b10,
    STOREUC   = 2'b11
  } cmp_e;
  localparam logic [3:0] KEY_CLEAR  = 4'd7;
  localparam logic [3:0] KEY_ENTER  = 4'd8;
  localparam logic [3:0] KEY_CHANGE = 4'd9;
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that holds at zero and flags terminal count
module lock_timer #(
  parameter int W = 8
) (
  input  logic         hwclk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge hwclk) begin
    if (rst) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign tc = (cnt_q == '0);
endmodule

// File: rtl/lock_controller.sv
// lock_controller: lock sequencer driving the code checker, attempt counter and timers
module lock_controller
  import lock_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 120_000_000,
  parameter int UNLOCK_CYCLES  = 60_000_000,
  parameter int IDLE_CYCLES    = 120_000_000
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       chk_correct,
  input  logic       chk_dataready,
  output logic [1:0] chk_compare_type,
  output logic       chk_read_input,
  output logic       chk_store,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] fail_cnt,
  output logic [2:0] state_dbg
);
  localparam int TW = timer_w(LOCKOUT_CYCLES, UNLOCK_CYCLES, IDLE_CYCLES);
  localparam logic [1:0] MAX_F = 2'(MAX_ATTEMPTS);
  state_e state_q, state_d;
  cmp_e cmp_q, cmp_d;
  logic pend_q, pend_d;
  logic [1:0] fail_q, fail_d;
  logic read_q, read_d, store_q, store_d, unl_q, unl_d, lko_q, lko_d;
  logic key, enter, ok, idle_st, timed, expired, tc, load;
  logic [TW-1:0] load_val;
  lock_timer #(.W(TW)) u_timer (
    .hwclk(hwclk), .rst(rst), .load(load), .load_val(load_val), .tc(tc)
  );
  always_comb begin
    key = key_valid & ~pend_q;
    enter = key & (key_code == KEY_ENTER);
    ok = chk_correct & chk_dataready;
    idle_st = state_q inside {S_AUTH_PC, S_NEW_UC, S_CONFIRM_UC};
    timed = idle_st | (state_q == S_LOCKOUT) | (state_q == S_UNLOCKED);
    expired = timed & tc;
    state_d = state_q;
    pend_d = 1'b0;
    fail_d = fail_q;
    if (expired) begin
      state_d = S_LOCKED;
      fail_d = (state_q == S_LOCKOUT) ? 2'd0 : fail_q;
    end else if (state_q == S_COMMIT) begin
      state_d = S_LOCKED;
      fail_d = 2'd0;
    end else if (pend_q) begin
      case (state_q)
        S_LOCKED: begin
          state_d = ok ? S_UNLOCKED : (fail_q >= MAX_F - 2'd1) ? S_LOCKOUT : S_LOCKED;
          fail_d = ok ? 2'd0 : (fail_q >= MAX_F - 2'd1) ? MAX_F : fail_q + 2'd1;
        end
        S_AUTH_PC:    state_d = ok ? S_NEW_UC : S_LOCKED;
        S_NEW_UC:     state_d = S_CONFIRM_UC;
        S_CONFIRM_UC: state_d = ok ? S_COMMIT : S_UNLOCKED;
        default:      state_d = state_q;
      endcase
    end else if (key) begin
      if (state_q == S_UNLOCKED)
        state_d = (key_code == KEY_CLEAR) ? S_LOCKED : (key_code == KEY_CHANGE) ? S_AUTH_PC : S_UNLOCKED;
      else
        pend_d = enter & ((state_q == S_LOCKED) | idle_st);
    end
    load = (state_d != state_q) | (idle_st & key);
    load_val = (state_d == S_LOCKOUT) ? TW'(LOCKOUT_CYCLES - 1) :
               (state_d == S_UNLOCKED) ? TW'(UNLOCK_CYCLES - 1) : TW'(IDLE_CYCLES - 1);
    cmp_d = (state_d == S_AUTH_PC) ? COMPAREPC : (state_d == S_NEW_UC) ? STOREUC :
            (state_d == S_CONFIRM_UC) ? MATCHUC : COMPAREUC;
    read_d = state_d inside {S_LOCKED, S_AUTH_PC, S_NEW_UC, S_CONFIRM_UC};
    store_d = (state_d == S_COMMIT);
    unl_d = (state_d == S_UNLOCKED);
    lko_d = (state_d == S_LOCKOUT);
  end
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q <= S_LOCKED;
      pend_q <= 1'b0;
      fail_q <= 2'd0;
      cmp_q <= COMPAREUC;
      read_q <= 1'b1;
      store_q <= 1'b0;
      unl_q <= 1'b0;
      lko_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      fail_q <= fail_d;
      cmp_q <= cmp_d;
      read_q <= read_d;
      store_q <= store_d;
      unl_q <= unl_d;
      lko_q <= lko_d;
    end
  end
  assign chk_compare_type = cmp_q;
  assign chk_read_input = read_q;
  assign chk_store = store_q;
  assign unlocked = unl_q;
  assign lockout = lko_q;
  assign fail_cnt = fail_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed and random stimulus checked against a timestamp-based lock model
module tb_lock_controller;
  import lock_pkg::*;
  localparam int LO = 50;
  localparam int UN = 30;
  localparam int ID = 40;
  logic hwclk = 1'b0;
  logic rst = 1'b1;
  logic key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic chk_correct = 1'b0;
  logic chk_dataready = 1'b0;
  logic [1:0] chk_compare_type;
  logic chk_read_input, chk_store, unlocked, lockout;
  logic [1:0] fail_cnt;
  logic [2:0] state_dbg;
  int n_chk = 0;
  int n_pass = 0;
  state_e m_st = S_LOCKED;
  int m_fail = 0;
  int m_t0 = 0;
  int cyc = 0;
  bit m_ev = 0;
  lock_controller #(
    .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(LO), .UNLOCK_CYCLES(UN), .IDLE_CYCLES(ID)
  ) dut (
    .hwclk(hwclk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .chk_correct(chk_correct), .chk_dataready(chk_dataready),
    .chk_compare_type(chk_compare_type), .chk_read_input(chk_read_input),
    .chk_store(chk_store), .unlocked(unlocked), .lockout(lockout),
    .fail_cnt(fail_cnt), .state_dbg(state_dbg)
  );
  always #5 hwclk = ~hwclk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic model(input bit r, input bit kv, input logic [3:0] kc, input bit c, input bit d);
    state_e ns;
    bit key, ok, idle, expire, nev;
    int lim;
    if (r) begin
      m_st = S_LOCKED;
      m_fail = 0;
      m_ev = 0;
    end else begin
      ok = c && d;
      key = kv && !m_ev;
      idle = m_st inside {S_AUTH_PC, S_NEW_UC, S_CONFIRM_UC};
      lim = (m_st == S_LOCKOUT) ? LO : (m_st == S_UNLOCKED) ? UN : idle ? ID : 0;
      expire = (lim != 0) && (cyc - m_t0 + 1 >= lim);
      ns = m_st;
      nev = 0;
      if (expire) begin
        if (m_st == S_LOCKOUT) m_fail = 0;
        ns = S_LOCKED;
      end else if (m_st == S_COMMIT) begin
        ns = S_LOCKED;
        m_fail = 0;
      end else if (m_ev) begin
        case (m_st)
          S_LOCKED: begin
            if (ok) begin
              ns = S_UNLOCKED;
              m_fail = 0;
            end else begin
              m_fail = m_fail + 1;
              if (m_fail >= 3) ns = S_LOCKOUT;
            end
          end
          S_AUTH_PC:    ns = ok ? S_NEW_UC : S_LOCKED;
          S_NEW_UC:     ns = S_CONFIRM_UC;
          S_CONFIRM_UC: ns = ok ? S_COMMIT : S_UNLOCKED;
          default:      ns = m_st;
        endcase
      end else if (key) begin
        if (m_st == S_UNLOCKED) ns = (kc == 7) ? S_LOCKED : (kc == 9) ? S_AUTH_PC : m_st;
        else if (m_st == S_LOCKED || idle) nev = (kc == 8);
      end
      if (ns != m_st || (idle && key)) m_t0 = cyc + 1;
      m_st = ns;
      m_ev = nev;
    end
    cyc++;
  endtask
  task automatic compare_all();
    check("state", int'(state_dbg), int'(m_st));
    check("type", int'(chk_compare_type), (m_st == S_AUTH_PC) ? 0 : (m_st == S_NEW_UC) ? 3 :
          (m_st == S_CONFIRM_UC) ? 2 : 1);
    check("read", int'(chk_read_input), int'(m_st inside {S_LOCKED, S_AUTH_PC, S_NEW_UC, S_CONFIRM_UC}));
    check("store", int'(chk_store), int'(m_st == S_COMMIT));
    check("unlocked", int'(unlocked), int'(m_st == S_UNLOCKED));
    check("lockout", int'(lockout), int'(m_st == S_LOCKOUT));
    check("fail_cnt", int'(fail_cnt), m_fail);
  endtask
  task automatic step(input bit r, input bit kv, input logic [3:0] kc, input bit c, input bit d);
    rst = r;
    key_valid = kv;
    key_code = kc;
    chk_correct = c;
    chk_dataready = d;
    model(r, kv, kc, c, d);
    @(posedge hwclk);
    @(negedge hwclk);
    compare_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 0);
  endtask
  task automatic press(input logic [3:0] k, input bit ok);
    step(0, 1, k, 0, 0);
    if (k == KEY_ENTER) step(0, 0, 4'd0, ok, 1);
  endtask
  initial begin
    @(negedge hwclk);
    step(1, 0, 4'd0, 0, 0);
    step(1, 0, 4'd0, 0, 0);
    check("rst_type", int'(chk_compare_type), 1);
    check("rst_read", int'(chk_read_input), 1);
    press(KEY_ENTER, 1);
    check("unlock", int'(unlocked), 1);
    idle(UN - 1);
    check("unlock_hold", int'(unlocked), 1);
    idle(1);
    check("relock", int'(unlocked), 0);
    press(KEY_ENTER, 0);
    check("fail1", int'(fail_cnt), 1);
    press(KEY_ENTER, 0);
    check("fail2", int'(fail_cnt), 2);
    press(KEY_ENTER, 0);
    check("lockout_on", int'(lockout), 1);
    press(KEY_CLEAR, 0);
    press(KEY_ENTER, 1);
    idle(LO - 4);
    check("lockout_hold", int'(lockout), 1);
    idle(1);
    check("lockout_off", int'(lockout), 0);
    check("fail_clr", int'(fail_cnt), 0);
    press(KEY_ENTER, 1);
    press(KEY_CHANGE, 0);
    check("auth_type", int'(chk_compare_type), 0);
    press(4'd3, 0);
    press(KEY_ENTER, 1);
    check("new_type", int'(chk_compare_type), 3);
    press(4'd5, 0);
    press(KEY_CLEAR, 0);
    press(KEY_ENTER, 0);
    check("confirm_type", int'(chk_compare_type), 2);
    press(KEY_ENTER, 1);
    check("store_on", int'(chk_store), 1);
    idle(1);
    check("store_off", int'(chk_store), 0);
    check("commit_lock", int'(state_dbg), int'(S_LOCKED));
    press(KEY_ENTER, 1);
    press(KEY_CHANGE, 0);
    press(KEY_ENTER, 1);
    press(KEY_ENTER, 1);
    press(KEY_ENTER, 0);
    check("confirm_bad", int'(unlocked), 1);
    press(KEY_CHANGE, 0);
    idle(ID - 1);
    check("auth_hold", int'(state_dbg), int'(S_AUTH_PC));
    idle(1);
    check("auth_idle", int'(state_dbg), int'(S_LOCKED));
    press(KEY_ENTER, 1);
    press(KEY_CHANGE, 0);
    press(KEY_ENTER, 1);
    step(1, 0, 4'd0, 0, 0);
    check("rst_new", int'(state_dbg), int'(S_LOCKED));
    press(KEY_ENTER, 1);
    press(KEY_CHANGE, 0);
    press(KEY_ENTER, 1);
    press(KEY_ENTER, 1);
    step(0, 1, KEY_ENTER, 0, 0);
    step(1, 0, 4'd0, 1, 1);
    check("rst_pend_store", int'(chk_store), 0);
    press(KEY_ENTER, 1);
    idle(UN - 1);
    step(0, 1, KEY_CHANGE, 0, 0);
    check("expiry_wins", int'(state_dbg), int'(S_LOCKED));
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] kc;
      int sel;
      sel = $urandom_range(0, 3);
      kc = (sel == 0) ? KEY_CLEAR : (sel == 1) ? KEY_ENTER : (sel == 2) ? KEY_CHANGE : 4'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, kc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
